// File: rtl/dsp_mac_sequencer.sv
// DSP48A1 multiply-accumulate sequencer: streams operand pairs into the
// slice, steers OPMODE/CE along its pipeline and returns the P result.
// Ports: clk, rst_n; start/len/busy job control; in_valid/in_ready/in_a/in_b
// operand stream; dsp_* slice controls and dsp_p; res_valid/res_ready/res_data.
module dsp_mac_sequencer #(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int P_W      = 48,
  parameter int LEN_W    = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic             dsp_ce_ab,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  output logic [7:0]       dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  output logic             res_valid,
  output logic [P_W-1:0]   res_data,
  input  logic             res_ready
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCUM, DRAIN, DONE
  } state_t;

  state_t st, st_nx;

  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;
  logic                ab_vld;
  logic                ab_first;
  logic [PIPE_LAT-1:0] v_pipe;
  logic [PIPE_LAT-1:0] f_pipe;
  logic                settle;
  logic                acc;
  logic                active;
  logic                pipe_empty;
  logic                p_vld;
  logic                p_first;

  assign acc        = in_valid & in_ready;
  assign active     = (st == CLEAR) | (st == ACCUM) | (st == DRAIN);
  assign pipe_empty = ~ab_vld & ~(|v_pipe);
  assign p_vld      = v_pipe[PIPE_LAT-1];
  assign p_first    = f_pipe[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (start) st_nx = (len == '0) ? DONE : CLEAR;
      end
      CLEAR: st_nx = ACCUM;
      ACCUM: begin
        if (acc && (cnt == len_q - 1'b1)) st_nx = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty && settle) st_nx = DONE;
      end
      DONE: begin
        if (res_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (st != IDLE);
    in_ready   = (st == ACCUM) && (cnt < len_q);
    dsp_ce_ab  = active;
    dsp_rstp   = (st == CLEAR);
    dsp_cep    = active & p_vld;
    dsp_opmode = 8'h00;
    if (active) dsp_opmode = (p_vld & p_first) ? 8'h01 : 8'h09;
    res_valid  = (st == DONE);
  end

  // ab_vld tracks the operand register stage, v_pipe the slice's
  // internal stages up to the P adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      cnt      <= '0;
      ab_vld   <= 1'b0;
      ab_first <= 1'b0;
      v_pipe   <= '0;
      f_pipe   <= '0;
      settle   <= 1'b0;
      dsp_a    <= '0;
      dsp_b    <= '0;
      res_data <= '0;
    end else begin
      if (st == IDLE && start) begin
        len_q <= len;
        if (len == '0) res_data <= '0;
      end
      if (st == CLEAR) begin
        cnt      <= '0;
        ab_vld   <= 1'b0;
        ab_first <= 1'b0;
        v_pipe   <= '0;
        f_pipe   <= '0;
        settle   <= 1'b0;
      end else begin
        ab_vld    <= acc;
        ab_first  <= acc & (cnt == '0);
        v_pipe[0] <= ab_vld;
        f_pipe[0] <= ab_first;
        for (int i = 1; i < PIPE_LAT; i++) begin
          v_pipe[i] <= v_pipe[i-1];
          f_pipe[i] <= f_pipe[i-1];
        end
        if (acc) begin
          cnt   <= cnt + 1'b1;
          dsp_a <= in_a;
          dsp_b <= in_b;
        end
        // one extra cycle after the pipe empties lets P settle
        if (st == DRAIN && pipe_empty) begin
          settle <= 1'b1;
          if (settle) res_data <= dsp_p;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A/B reg, two M stages, P reg) matching PIPE_LAT=3.
module tb_dsp_mac_sequencer;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int P_W = 48;
  localparam int LEN_W = 16;
  localparam int PIPE_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic busy;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [A_W-1:0] in_a = '0;
  logic [B_W-1:0] in_b = '0;
  logic [A_W-1:0] dsp_a;
  logic [B_W-1:0] dsp_b;
  logic dsp_ce_ab, dsp_cep, dsp_rstp;
  logic [7:0] dsp_opmode;
  logic [P_W-1:0] dsp_p;
  logic res_valid;
  logic [P_W-1:0] res_data;
  logic res_ready = 1'b0;

  dsp_mac_sequencer #(
    .A_W(A_W), .B_W(B_W), .P_W(P_W),
    .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_ce_ab(dsp_ce_ab), .dsp_cep(dsp_cep),
    .dsp_rstp(dsp_rstp), .dsp_opmode(dsp_opmode),
    .dsp_p(dsp_p),
    .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // behavioural slice
  logic signed [A_W-1:0] a_r;
  logic signed [B_W-1:0] b_r;
  logic signed [P_W-1:0] m1, m2, p_r;
  assign dsp_p = p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; m1 <= '0; m2 <= '0; p_r <= '0;
    end else begin
      if (dsp_ce_ab) begin
        a_r <= dsp_a;
        b_r <= dsp_b;
        m1  <= a_r * b_r;
        m2  <= m1;
      end
      if (dsp_rstp) p_r <= '0;
      else if (dsp_cep) p_r <= (dsp_opmode == 8'h01) ? m2 : p_r + m2;
    end
  end

  // activity monitor
  int cyc = 0;
  int last_acc = 0;
  int n_cep = 0;
  int n_ceab = 0;
  int n_first = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) last_acc <= cyc + 1;
    if (dsp_cep) n_cep <= n_cep + 1;
    if (dsp_ce_ab) n_ceab <= n_ceab + 1;
    if (dsp_cep && dsp_opmode == 8'h01) n_first <= n_first + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [P_W-1:0] obs,
                       input logic [P_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic signed [A_W-1:0] av [8];
  logic signed [B_W-1:0] bv [8];

  task automatic start_job(input int n);
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: in_valid always 1; mode 1: pattern 1,0,0,1,0,0,...
  task automatic feed(input int n, input int mode);
    int i = 0;
    int slot = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (mode == 0 || slot % 3 == 0) begin
        in_valid = 1'b1;
        in_a = av[i];
        in_b = bv[i];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) i++;
      slot++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("feed_timeout", P_W'(guard < 200), P_W'(1));
  endtask

  int seen_cyc;
  task automatic wait_res();
    int guard = 0;
    while (!res_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    seen_cyc = cyc;
    check("res_timeout", P_W'(res_valid), P_W'(1));
  endtask

  task automatic ack();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("ack_rv_low", P_W'(res_valid), P_W'(0));
    check("ack_idle", P_W'(busy), P_W'(0));
  endtask

  int c0, c1, f0;
  logic [P_W-1:0] held;

  initial begin
    #2;
    check("rst_busy", P_W'(busy), P_W'(0));
    check("rst_rv", P_W'(res_valid), P_W'(0));
    check("rst_opm", P_W'(dsp_opmode), P_W'(0));
    check("rst_ceab", P_W'(dsp_ce_ab), P_W'(0));
    #20;
    rst_n = 1'b1;

    // job 1: streaming, latency check
    av[0] = 1; av[1] = 2; av[2] = 3; av[3] = 4;
    bv[0] = 5; bv[1] = 6; bv[2] = 7; bv[3] = 8;
    start_job(4);
    check("busy_run", P_W'(busy), P_W'(1));
    feed(4, 0);
    wait_res();
    check("j1_data", res_data, P_W'(70));
    check("j1_lat", P_W'(seen_cyc - last_acc), P_W'(PIPE_LAT + 3));
    ack();

    // job 2: bubbles
    c0 = n_cep;
    start_job(4);
    feed(4, 1);
    wait_res();
    check("j2_data", res_data, P_W'(70));
    check("j2_cep", P_W'(n_cep - c0), P_W'(4));
    ack();

    // job 3: single negative term
    f0 = n_first;
    av[0] = -3; bv[0] = 5;
    start_job(1);
    feed(1, 0);
    wait_res();
    check("j3_data", res_data, 48'hFFFF_FFFF_FFF1);
    check("j3_first", P_W'(n_first - f0), P_W'(1));
    ack();

    // job 4: extreme operands
    av[0] = -131072; bv[0] = -131072;
    av[1] = -131072; bv[1] = 131071;
    start_job(2);
    feed(2, 0);
    wait_res();
    check("j4_data", res_data, P_W'(131072));
    ack();

    // job 5: len=0
    c0 = n_cep;
    c1 = n_ceab;
    start_job(0);
    check("z_rv", P_W'(res_valid), P_W'(1));
    check("z_data", res_data, P_W'(0));
    check("z_cep", P_W'(n_cep - c0), P_W'(0));
    check("z_ceab", P_W'(n_ceab - c1), P_W'(0));
    ack();

    // job 6: back-pressure on result, start ignored
    av[0] = 10; av[1] = -20; av[2] = 7;
    bv[0] = 3; bv[1] = 4; bv[2] = -5;
    start_job(3);
    feed(3, 0);
    wait_res();
    held = res_data;
    check("j6_data", held, 48'hFFFF_FFFF_FFAB);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 6);
      len = 16'd7;
      check("hold_rv", P_W'(res_valid), P_W'(1));
      check("hold_data", res_data, 48'hFFFF_FFFF_FFAB);
    end
    start = 1'b0;
    ack();

    // job 7: async reset mid-accumulate
    av[0] = 9; av[1] = 11; bv[0] = 13; bv[1] = 17;
    start_job(5);
    feed(2, 0);
    check("pre_rst_busy", P_W'(busy), P_W'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_busy", P_W'(busy), P_W'(0));
    check("ar_rdy", P_W'(in_ready), P_W'(0));
    check("ar_a", P_W'(dsp_a), P_W'(0));
    check("ar_b", P_W'(dsp_b), P_W'(0));
    check("ar_ceab", P_W'(dsp_ce_ab), P_W'(0));
    check("ar_cep", P_W'(dsp_cep), P_W'(0));
    check("ar_rstp", P_W'(dsp_rstp), P_W'(0));
    check("ar_opm", P_W'(dsp_opmode), P_W'(0));
    check("ar_rv", P_W'(res_valid), P_W'(0));
    check("ar_data", res_data, P_W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    av[0] = 2; av[1] = 4; bv[0] = 3; bv[1] = 5;
    start_job(2);
    feed(2, 0);
    wait_res();
    check("j7_data", res_data, P_W'(26));
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
